// File: rtl/net_pkg.sv
// Shared types and width helpers for the layer sequencer.
// FSM encoding, address/accumulator sizing and saturation bounds.
package net_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_BIAS,
    S_OUT,
    S_DONE
  } state_e;

  localparam int DATA_W_DEFAULT = 8;

  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int acc_w(input int dw, input int pren);
    return 2 * dw + $clog2(pren) + 1;
  endfunction

  function automatic longint sat_hi(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Memory read ports and result handshake of the layer sequencer.
// master = sequencer side, slave = memories and result consumer.
interface layer_sequencer_if
  import net_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int N         = 1,
  parameter int PreN      = 192
);
  localparam int IAW = addr_w(PreN);
  localparam int WAW = addr_w(N * PreN);
  localparam int NAW = addr_w(N);

  logic [IAW-1:0]              in_addr;
  logic [WAW-1:0]              w_addr;
  logic [NAW-1:0]              b_addr;
  logic signed [DataWidth-1:0] in_data;
  logic signed [DataWidth-1:0] w_data;
  logic signed [DataWidth-1:0] b_data;

  logic                        out_valid;
  logic                        out_ready;
  logic [NAW-1:0]              out_addr;
  logic signed [DataWidth-1:0] out_data;

  modport master (
    output in_addr, w_addr, b_addr,
    input  in_data, w_data, b_data,
    output out_valid, out_addr, out_data,
    input  out_ready
  );

  modport slave (
    input  in_addr, w_addr, b_addr,
    output in_data, w_data, b_data,
    input  out_valid, out_addr, out_data,
    output out_ready
  );

endinterface

// File: rtl/net_mac_unit.sv
// Multiply-accumulate, bias add, fraction shift and saturation.
// Define LAYER_SEQ_RELU_EN to clamp negative results to zero.
module net_mac_unit
  import net_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int PreN      = 192,
  parameter int FracBits  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic signed [DataWidth-1:0] a_i,
  input  logic signed [DataWidth-1:0] b_i,
  input  logic signed [DataWidth-1:0] bias_i,
  output logic signed [DataWidth-1:0] res_o
);
  localparam int PW = 2 * DataWidth;
  localparam int AW = acc_w(DataWidth, PreN);
  localparam int SW = AW + 1;

  localparam logic signed [SW-1:0] HI = SW'(sat_hi(DataWidth));
  localparam logic signed [SW-1:0] LO = SW'(sat_lo(DataWidth));

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [SW-1:0] bias_ext, bias_sh;
  logic signed [SW-1:0] sum, shr, clip;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Bias is aligned to the accumulator's fixed-point scale before adding.
  assign bias_ext = {{(SW-DataWidth){bias_i[DataWidth-1]}}, bias_i};
  assign bias_sh  = bias_ext <<< FracBits;
  assign sum      = {acc_q[AW-1], acc_q} + bias_sh;
  assign shr      = sum >>> FracBits;

  always_comb begin
    clip = shr;
`ifdef LAYER_SEQ_RELU_EN
    if (shr[SW-1]) begin
      clip = '0;
    end
`endif
    if (clip > HI) begin
      res_o = HI[DataWidth-1:0];
    end else if (clip < LO) begin
      res_o = LO[DataWidth-1:0];
    end else begin
      res_o = clip[DataWidth-1:0];
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Walks one neuron layer: MAC over PreN inputs, bias, emit, repeat.
// Optional ReLU on results via LAYER_SEQ_RELU_EN (see net_mac_unit).
module layer_sequencer
  import net_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int N         = 1,
  parameter int PreN      = 192,
  parameter int FracBits  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  layer_sequencer_if.master bus
);
  localparam int IAW = addr_w(PreN);
  localparam int WAW = addr_w(N * PreN);
  localparam int NAW = addr_w(N);
  localparam int CW  = addr_w(PreN + 1);

  state_e                      state_q;
  logic [CW-1:0]               cyc_q;
  logic [NAW-1:0]              j_q;
  logic [IAW-1:0]              in_addr_q;
  logic [WAW-1:0]              w_addr_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        valid_q;
  logic signed [DataWidth-1:0] out_data_q;

  logic                        mac_clr;
  logic                        mac_en;
  logic signed [DataWidth-1:0] mac_res;

  // Accumulator is only live in MAC/BIAS; clearing elsewhere gives a clean entry.
  assign mac_clr = (state_q != S_MAC) && (state_q != S_BIAS);
  assign mac_en  = (state_q == S_MAC) && (cyc_q != '0);

  net_mac_unit #(
    .DataWidth (DataWidth),
    .PreN      (PreN),
    .FracBits  (FracBits)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .a_i    (bus.in_data),
    .b_i    (bus.w_data),
    .bias_i (bus.b_data),
    .res_o  (mac_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      j_q        <= '0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_MAC;
            busy_q    <= 1'b1;
            cyc_q     <= '0;
            j_q       <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
          end
        end
        S_MAC: begin
          if (cyc_q < CW'(PreN - 1)) begin
            in_addr_q <= in_addr_q + IAW'(1);
            w_addr_q  <= w_addr_q + WAW'(1);
          end
          if (cyc_q == CW'(PreN)) begin
            state_q <= S_BIAS;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        S_BIAS: begin
          out_data_q <= mac_res;
          valid_q    <= 1'b1;
          state_q    <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            if (j_q == NAW'(N - 1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // Weight rows are contiguous, so the next row follows the last k.
              j_q       <= j_q + NAW'(1);
              state_q   <= S_MAC;
              cyc_q     <= '0;
              in_addr_q <= '0;
              w_addr_q  <= w_addr_q + WAW'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_addr   = in_addr_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.b_addr    = j_q;
  assign bus.out_valid = valid_q;
  assign bus.out_addr  = j_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: vector tables, corner sequences, random vs model.
// Two instances: N=2/PreN=4/FracBits=0 and N=1/PreN=1/FracBits=2.
module tb_layer_sequencer;
  localparam int DW = 8;
  localparam int NA = 2;
  localparam int PA = 4;
  localparam int NB = 1;
  localparam int PB = 1;
  localparam int FB = 2;

`ifdef LAYER_SEQ_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, busy_a, done_a;
  logic rst_b, start_b, busy_b, done_b;

  layer_sequencer_if #(.DataWidth(DW), .N(NA), .PreN(PA)) ba ();
  layer_sequencer_if #(.DataWidth(DW), .N(NB), .PreN(PB)) bb ();

  layer_sequencer #(
    .DataWidth(DW), .N(NA), .PreN(PA), .FracBits(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a),
    .busy(busy_a), .done(done_a), .bus(ba)
  );

  layer_sequencer #(
    .DataWidth(DW), .N(NB), .PreN(PB), .FracBits(FB)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b),
    .busy(busy_b), .done(done_b), .bus(bb)
  );

  logic signed [DW-1:0] mi_a [4];
  logic signed [DW-1:0] mw_a [8];
  logic signed [DW-1:0] mb_a [2];
  logic signed [DW-1:0] mi_b [2];
  logic signed [DW-1:0] mw_b [2];
  logic signed [DW-1:0] mb_b [2];

  // Synchronous-read memories: data one cycle after the address.
  always @(posedge clk) begin
    ba.in_data <= mi_a[ba.in_addr];
    ba.w_data  <= mw_a[ba.w_addr];
    ba.b_data  <= mb_a[ba.b_addr];
    bb.in_data <= mi_b[bb.in_addr];
    bb.w_data  <= mw_b[bb.w_addr];
    bb.b_data  <= mb_b[bb.b_addr];
  end

  typedef struct {
    int iv;
    int wv;
    int bv;
    int ev;
  } vec_t;

  vec_t va [8];
  vec_t vb [5];

  int n_chk  = 0;
  int n_pass = 0;
  int got_addr [$];
  int got_data [$];
  int exp_a [NA];

  task automatic chk(input string nm, input longint act, input longint want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, want);
  endtask

  function automatic int rl(input int v);
    return (RELU && v < 0) ? 0 : v;
  endfunction

  // Reference: exact dot product, scaled bias, floor shift, ReLU, clamp.
  function automatic int model(input longint dot, input longint b, input int fb);
    longint s;
    longint r;
    s = dot + (b <<< fb);
    r = s >>> fb;
    if (RELU && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  function automatic logic signed [DW-1:0] rv(input bit sm);
    int t;
    t = sm ? int'($urandom_range(0, 15)) - 8 : int'($urandom_range(0, 255)) - 128;
    return DW'(t);
  endfunction

  task automatic rst_chk_a(input string tg);
    chk({tg, "_busy"}, busy_a, 0);
    chk({tg, "_done"}, done_a, 0);
    chk({tg, "_valid"}, ba.out_valid, 0);
    chk({tg, "_odata"}, ba.out_data, 0);
    chk({tg, "_oaddr"}, ba.out_addr, 0);
    chk({tg, "_inaddr"}, ba.in_addr, 0);
    chk({tg, "_waddr"}, ba.w_addr, 0);
    chk({tg, "_baddr"}, ba.b_addr, 0);
  endtask

  task automatic run_a(input int stall_j, input int stall_n,
                       input int poke_c, output int lat);
    int st;
    bit nxt;
    int hd;
    int ha;
    st = 0;
    nxt = 1'b0;
    hd = 0;
    ha = 0;
    lat = -1;
    got_addr.delete();
    got_data.delete();
    ba.out_ready = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("busy_on_start", busy_a, 1);
    for (int c = 0; c < 300; c++) begin
      start_a = (c == poke_c);
      if (nxt) begin
        chk("release_valid", ba.out_valid, 0);
        chk("release_waddr", ba.w_addr, (stall_j + 1) * PA);
        chk("release_baddr", ba.b_addr, stall_j + 1);
        nxt = 1'b0;
      end
      if (done_a) begin
        lat = c + 1;
        break;
      end
      if (st > 0 && st <= stall_n) begin
        chk("stall_valid", ba.out_valid, 1);
        chk("stall_data", ba.out_data, hd);
        chk("stall_addr", ba.out_addr, ha);
        st++;
        ba.out_ready = (st > stall_n);
        if (st > stall_n) begin
          got_addr.push_back(int'(ba.out_addr));
          got_data.push_back(int'(ba.out_data));
          nxt = (stall_j < NA - 1);
        end
      end else if (ba.out_valid) begin
        if (stall_n > 0 && st == 0 && int'(ba.out_addr) == stall_j) begin
          hd = int'(ba.out_data);
          ha = int'(ba.out_addr);
          st = 1;
          ba.out_ready = 1'b0;
        end else begin
          ba.out_ready = 1'b1;
          got_addr.push_back(int'(ba.out_addr));
          got_data.push_back(int'(ba.out_data));
        end
      end
      @(negedge clk);
    end
    @(negedge clk);
    start_a = 1'b0;
    ba.out_ready = 1'b1;
    chk("done_one_cycle", done_a, 0);
    chk("busy_after_done", busy_a, 0);
  endtask

  task automatic cmp_a(input string tg);
    chk({tg, "_count"}, got_data.size(), NA);
    for (int j = 0; j < NA && j < got_data.size(); j++) begin
      chk({tg, "_addr"}, got_addr[j], j);
      chk({tg, "_data"}, got_data[j], exp_a[j]);
    end
  endtask

  task automatic fill_a(input int iv, input int wv, input int bv);
    for (int k = 0; k < PA; k++) mi_a[k] = DW'(iv);
    for (int k = 0; k < NA * PA; k++) mw_a[k] = DW'(wv);
    for (int j = 0; j < NA; j++) mb_a[j] = DW'(bv);
  endtask

  task automatic run_b(input int expd);
    int lat;
    int nv;
    lat = -1;
    nv = 0;
    bb.out_ready = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (done_b) begin
        lat = c + 1;
        break;
      end
      if (bb.out_valid) begin
        nv++;
        chk("b_data", bb.out_data, expd);
        chk("b_addr", bb.out_addr, 0);
      end
      @(negedge clk);
    end
    chk("b_valid_count", nv, 1);
    chk("b_done_latency", lat, NB * (PB + 3) + 1);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int extra;
    longint dot;

    va[0] = '{1, 1, 0, 4};
    va[1] = '{127, 127, 0, 127};
    va[2] = '{127, -128, 0, -128};
    va[3] = '{2, -3, 5, -19};
    va[4] = '{0, 0, -7, -7};
    va[5] = '{10, 3, 2, 122};
    va[6] = '{-5, 6, -1, -121};
    va[7] = '{-6, 6, 0, -128};

    vb[0] = '{8, 2, 1, 5};
    vb[1] = '{-8, 2, 1, -3};
    vb[2] = '{3, 3, 0, 2};
    vb[3] = '{-3, 3, 0, -3};
    vb[4] = '{127, 127, 0, 127};

    rst_a = 1'b1;
    rst_b = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    ba.out_ready = 1'b1;
    bb.out_ready = 1'b1;
    fill_a(0, 0, 0);
    repeat (3) @(negedge clk);
    rst_chk_a("reset");
    chk("reset_b_valid", bb.out_valid, 0);
    chk("reset_b_busy", busy_b, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      fill_a(va[i].iv, va[i].wv, va[i].bv);
      for (int j = 0; j < NA; j++) exp_a[j] = rl(va[i].ev);
      run_a(-1, 0, -1, lat);
      chk("tbl_latency", lat, NA * (PA + 3) + 1);
      cmp_a("tbl");
    end

    // Consumer stalls the first result for five cycles.
    for (int k = 0; k < PA; k++) mi_a[k] = DW'(k + 1);
    for (int k = 0; k < PA; k++) mw_a[k] = DW'(1);
    for (int k = 0; k < PA; k++) mw_a[PA + k] = DW'(2);
    mb_a[0] = DW'(1);
    mb_a[1] = DW'(-1);
    exp_a[0] = 11;
    exp_a[1] = 19;
    run_a(0, 5, -1, lat);
    chk("stall_latency", lat, NA * (PA + 3) + 1 + 5);
    cmp_a("stall");

    // Start re-asserted mid-layer and again while in DONE.
    fill_a(1, 1, 0);
    exp_a[0] = 4;
    exp_a[1] = 4;
    run_a(-1, 0, 3, lat);
    chk("poke_mac_latency", lat, 15);
    cmp_a("poke_mac");
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      extra += int'(done_a) + int'(busy_a);
    end
    chk("poke_mac_no_restart", extra, 0);
    run_a(-1, 0, 14, lat);
    chk("poke_done_latency", lat, 15);
    cmp_a("poke_done");
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      extra += int'(done_a) + int'(busy_a);
    end
    chk("poke_done_no_restart", extra, 0);

    // Reset during MAC cycle 2 of neuron 1.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_odata", ba.out_data, 4);
    chk("pre_rst_waddr", ba.w_addr, PA + 2);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    rst_chk_a("midrst");
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      extra += int'(ba.out_valid) + int'(busy_a) + int'(done_a);
    end
    chk("midrst_quiet", extra, 0);
    run_a(-1, 0, -1, lat);
    chk("midrst_rerun_latency", lat, 15);
    cmp_a("midrst_rerun");

    for (int it = 0; it < 25; it++) begin
      bit sm;
      sm = (it % 2) == 0;
      for (int k = 0; k < PA; k++) mi_a[k] = rv(sm);
      for (int k = 0; k < NA * PA; k++) mw_a[k] = rv(sm);
      for (int j = 0; j < NA; j++) mb_a[j] = rv(sm);
      for (int j = 0; j < NA; j++) begin
        dot = 0;
        for (int k = 0; k < PA; k++)
          dot += longint'(mi_a[k]) * longint'(mw_a[j * PA + k]);
        exp_a[j] = model(dot, longint'(mb_a[j]), 0);
      end
      run_a(-1, 0, -1, lat);
      chk("rnd_latency", lat, 15);
      cmp_a("rnd");
    end

    for (int i = 0; i < 5; i++) begin
      mi_b[0] = DW'(vb[i].iv);
      mw_b[0] = DW'(vb[i].wv);
      mb_b[0] = DW'(vb[i].bv);
      run_b(rl(vb[i].ev));
    end
    for (int it = 0; it < 15; it++) begin
      mi_b[0] = rv(it % 2 == 0);
      mw_b[0] = rv(it % 2 == 0);
      mb_b[0] = rv(1'b1);
      run_b(model(longint'(mi_b[0]) * longint'(mw_b[0]), longint'(mb_b[0]), FB));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
